// File: rtl/shield_hit_detector.sv
// Shield collision producer: per-pixel erase strobes for the shield bitmap
// and per-frame "shot blocked" events with first-hit coordinates.
module shield_hit_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic        playGame,
    input  logic        startOfFrame,
    input  logic        strobe,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        shotBlocked,
    output logic [10:0] hitX,
    output logic [10:0] hitY
);

    typedef enum logic {
        ARMED   = 1'b0,
        LATCHED = 1'b1
    } hitState_t;

    hitState_t state;

    logic capture;
    assign capture = strobe && (state == ARMED || startOfFrame);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARMED;
            shotBlocked <= 1'b0;
            hitX        <= '0;
            hitY        <= '0;
        end else if (!playGame) begin
            // Outside a game any pending hit is dropped; coordinates hold.
            state       <= ARMED;
            shotBlocked <= 1'b0;
        end else begin
            shotBlocked <= startOfFrame && (state == LATCHED);
            if (capture) begin
                // Frame boundary with a strobe opens the new frame latched.
                state <= LATCHED;
                hitX  <= pixelX;
                hitY  <= pixelY;
            end else if (startOfFrame) begin
                state <= ARMED;
            end
        end
    end

endmodule

module shield_hit_detector #(
    parameter int HIT_CNT_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic                 playGame,
    input  logic [10:0]          pixelX,
    input  logic [10:0]          pixelY,
    input  logic                 shieldDR,
    input  logic                 playerMissileDR,
    input  logic                 alienMissileDR,
    output logic                 collisionShield,
    output logic                 collisionShield_alien,
    output logic                 playerShotBlocked,
    output logic                 alienShotBlocked,
    output logic [10:0]          playerHitX,
    output logic [10:0]          playerHitY,
    output logic [10:0]          alienHitX,
    output logic [10:0]          alienHitY,
    output logic [HIT_CNT_W-1:0] blockedCount
);

    // Strobes stay combinational: the bitmap erases at the current offset.
    assign collisionShield       = shieldDR & playerMissileDR & playGame;
    assign collisionShield_alien = shieldDR & alienMissileDR & playGame;

    shield_hit_fsm playerFsm (
        .clk          (clk),
        .reset        (reset),
        .playGame     (playGame),
        .startOfFrame (startOfFrame),
        .strobe       (collisionShield),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .shotBlocked  (playerShotBlocked),
        .hitX         (playerHitX),
        .hitY         (playerHitY)
    );

    shield_hit_fsm alienFsm (
        .clk          (clk),
        .reset        (reset),
        .playGame     (playGame),
        .startOfFrame (startOfFrame),
        .strobe       (collisionShield_alien),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .shotBlocked  (alienShotBlocked),
        .hitX         (alienHitX),
        .hitY         (alienHitY)
    );

    logic                 playGameQ;
    logic                 gameStart;
    logic [1:0]           incr;
    logic [HIT_CNT_W:0]   sum;
    logic [HIT_CNT_W-1:0] satSum;

    assign gameStart = playGame & ~playGameQ;
    assign incr      = {1'b0, playerShotBlocked} + {1'b0, alienShotBlocked};
    assign sum       = {1'b0, blockedCount}
                     + {{(HIT_CNT_W-1){1'b0}}, incr};
    assign satSum    = sum[HIT_CNT_W] ? {HIT_CNT_W{1'b1}}
                                      : sum[HIT_CNT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            playGameQ    <= 1'b0;
            blockedCount <= '0;
        end else begin
            playGameQ <= playGame;
            if (gameStart) begin
                blockedCount <= '0;
            end else begin
                blockedCount <= satSum;
            end
        end
    end

endmodule

// File: tb/tb_shield_hit_detector.sv
// Directed bench for shield_hit_detector, with a 2-bit counter copy
// sharing the same stimulus to exercise saturation.
module tb_shield_hit_detector;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic        playGame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        shieldDR;
    logic        playerMissileDR;
    logic        alienMissileDR;

    logic        collisionShield;
    logic        collisionShield_alien;
    logic        playerShotBlocked;
    logic        alienShotBlocked;
    logic [10:0] playerHitX;
    logic [10:0] playerHitY;
    logic [10:0] alienHitX;
    logic [10:0] alienHitY;
    logic [9:0]  blockedCount;

    logic        c2Shield;
    logic        c2ShieldAlien;
    logic        p2Blocked;
    logic        a2Blocked;
    logic [10:0] p2X;
    logic [10:0] p2Y;
    logic [10:0] a2X;
    logic [10:0] a2Y;
    logic [1:0]  count2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shield_hit_detector #(.HIT_CNT_W(10)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .startOfFrame          (startOfFrame),
        .playGame              (playGame),
        .pixelX                (pixelX),
        .pixelY                (pixelY),
        .shieldDR              (shieldDR),
        .playerMissileDR       (playerMissileDR),
        .alienMissileDR        (alienMissileDR),
        .collisionShield       (collisionShield),
        .collisionShield_alien (collisionShield_alien),
        .playerShotBlocked     (playerShotBlocked),
        .alienShotBlocked      (alienShotBlocked),
        .playerHitX            (playerHitX),
        .playerHitY            (playerHitY),
        .alienHitX             (alienHitX),
        .alienHitY             (alienHitY),
        .blockedCount          (blockedCount)
    );

    shield_hit_detector #(.HIT_CNT_W(2)) dut2 (
        .clk                   (clk),
        .reset                 (reset),
        .startOfFrame          (startOfFrame),
        .playGame              (playGame),
        .pixelX                (pixelX),
        .pixelY                (pixelY),
        .shieldDR              (shieldDR),
        .playerMissileDR       (playerMissileDR),
        .alienMissileDR        (alienMissileDR),
        .collisionShield       (c2Shield),
        .collisionShield_alien (c2ShieldAlien),
        .playerShotBlocked     (p2Blocked),
        .alienShotBlocked      (a2Blocked),
        .playerHitX            (p2X),
        .playerHitY            (p2Y),
        .alienHitX             (a2X),
        .alienHitY             (a2Y),
        .blockedCount          (count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic setDR(input logic s, input logic p, input logic a);
        shieldDR        = s;
        playerMissileDR = p;
        alienMissileDR  = a;
    endtask

    initial begin
        reset        = 1'b1;
        startOfFrame = 1'b0;
        playGame     = 1'b0;
        pixelX       = '0;
        pixelY       = '0;
        setDR(1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_count", int'(blockedCount), 0);
        chk("rst_pblk", int'(playerShotBlocked), 0);
        chk("rst_ablk", int'(alienShotBlocked), 0);
        chk("rst_px", int'(playerHitX), 0);
        chk("rst_ay", int'(alienHitY), 0);

        // strobes are stateless, so they follow inputs even in reset
        playGame = 1'b1;
        setDR(1'b1, 1'b1, 1'b0);
        #1;
        chk("rst_strobe", int'(collisionShield), 1);
        setDR(1'b0, 1'b0, 1'b0);
        playGame = 1'b0;
        step();
        reset = 1'b0;
        step();
        playGame = 1'b1;
        step();
        chk("start_count", int'(blockedCount), 0);

        // single overlap, three pixels
        pixelX = 11'd200;
        pixelY = 11'd360;
        setDR(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pixelX = 11'(200 + i);
            #1;
            chk("single_strobe", int'(collisionShield), 1);
            chk("single_astrobe", int'(collisionShield_alien), 0);
            step();
        end
        setDR(1'b0, 1'b0, 1'b0);
        chk("single_hx", int'(playerHitX), 200);
        chk("single_hy", int'(playerHitY), 360);
        chk("single_nopulse", int'(playerShotBlocked), 0);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        chk("single_pulse", int'(playerShotBlocked), 1);
        chk("single_apulse", int'(alienShotBlocked), 0);
        step();
        chk("single_pulse_end", int'(playerShotBlocked), 0);
        chk("single_count", int'(blockedCount), 1);

        // game gating: no strobes, no events, counter holds
        playGame = 1'b0;
        setDR(1'b1, 1'b1, 1'b1);
        #1;
        chk("gate_pstrobe", int'(collisionShield), 0);
        chk("gate_astrobe", int'(collisionShield_alien), 0);
        step();
        setDR(1'b0, 1'b0, 1'b0);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        chk("gate_pulse", int'(playerShotBlocked | alienShotBlocked), 0);
        step();
        chk("gate_count", int'(blockedCount), 1);

        // hit latched then game drops: hit discarded, coords held
        playGame = 1'b1;
        pixelX   = 11'd55;
        pixelY   = 11'd66;
        setDR(1'b1, 1'b1, 1'b0);
        step();
        setDR(1'b0, 1'b0, 1'b0);
        chk("rise_clear", int'(blockedCount), 0);
        playGame = 1'b0;
        step();
        playGame = 1'b1;
        step();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        chk("drop_nopulse", int'(playerShotBlocked), 0);
        chk("drop_hx", int'(playerHitX), 55);
        chk("drop_hy", int'(playerHitY), 66);
        step();

        // both sources in one frame
        pixelX = 11'd150;
        pixelY = 11'd370;
        setDR(1'b1, 1'b1, 1'b0);
        step();
        pixelX = 11'd400;
        pixelY = 11'd380;
        setDR(1'b1, 1'b0, 1'b1);
        #1;
        chk("both_astrobe", int'(collisionShield_alien), 1);
        step();
        setDR(1'b0, 1'b0, 1'b0);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        chk("both_ppulse", int'(playerShotBlocked), 1);
        chk("both_apulse", int'(alienShotBlocked), 1);
        chk("both_count0", int'(blockedCount), 0);
        step();
        chk("both_count2", int'(blockedCount), 2);
        chk("both_sat_count2", int'(count2), 2);
        chk("both_px", int'(playerHitX), 150);
        chk("both_py", int'(playerHitY), 370);
        chk("both_ax", int'(alienHitX), 400);
        chk("both_ay", int'(alienHitY), 380);

        // second dual frame: narrow counter saturates from 2 to 3
        pixelX = 11'd10;
        pixelY = 11'd20;
        setDR(1'b1, 1'b1, 1'b0);
        step();
        pixelX = 11'd30;
        pixelY = 11'd40;
        setDR(1'b1, 1'b0, 1'b1);
        step();
        setDR(1'b0, 1'b0, 1'b0);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        step();
        chk("dual2_count", int'(blockedCount), 4);
        chk("sat_count3", int'(count2), 3);

        // frame boundary coinciding with a new strobe
        pixelX = 11'd100;
        pixelY = 11'd356;
        setDR(1'b1, 1'b1, 1'b0);
        step();
        chk("sim_hx1", int'(playerHitX), 100);
        pixelX       = 11'd0;
        pixelY       = 11'd0;
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        setDR(1'b0, 1'b0, 1'b0);
        chk("sim_pulse", int'(playerShotBlocked), 1);
        chk("sim_hx0", int'(playerHitX), 0);
        chk("sim_hy0", int'(playerHitY), 0);
        step();
        chk("sim_count", int'(blockedCount), 5);
        chk("sat_hold1", int'(count2), 3);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        chk("sim_pulse2", int'(playerShotBlocked), 1);
        step();
        chk("sim_count2", int'(blockedCount), 6);
        chk("sat_hold2", int'(count2), 3);

        // rising playGame clears the counter
        playGame = 1'b0;
        step();
        chk("fall_hold", int'(blockedCount), 6);
        playGame = 1'b1;
        step();
        chk("rise_zero", int'(blockedCount), 0);
        chk("rise_zero2", int'(count2), 0);

        // reset mid-frame discards the latched hit
        pixelX = 11'd77;
        pixelY = 11'd88;
        setDR(1'b1, 1'b1, 1'b0);
        step();
        setDR(1'b0, 1'b0, 1'b0);
        chk("rstmid_hx", int'(playerHitX), 77);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstmid_px", int'(playerHitX), 0);
        chk("rstmid_py", int'(playerHitY), 0);
        chk("rstmid_count", int'(blockedCount), 0);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        chk("rstmid_nopulse", int'(playerShotBlocked), 0);
        step();
        chk("rstmid_nopulse2", int'(playerShotBlocked), 0);
        chk("rstmid_count2", int'(blockedCount), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
